mem_return: RTL and testbench

Return-path unit for main memory. It accepts the per-cycle request stream from the core's memory controller (read address, reload/choice, dstack and conveyor memloads, writes) and tracks each read through a fixed-latency synchronous memory. It steers the returned word to its destination: a dc value register, the data stack load port or the conveyor load port. In-flight reads are forwarded from any younger write to the same address, and stale dc reloads that have been superseded are dropped.

---
 rtl/mem_return_pkg.sv | 29 ++
 rtl/mem_return_stage.sv | 64 ++++++
 rtl/mem_return.sv | 207 ++++++++++++++++++++
 tb/tb_mem_return.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_return_pkg.sv
// mem_return_pkg: shared types for the main-memory return path.
//   kind_e       - what a tracked read is for (dc reload, data stack, conveyor)
//   stage_meta_t - width-independent part of one pipe stage; the address and
//                  forwarded word are carried beside it by the owning module
//                  because their widths are module parameters.
//   multi_hot3   - true when more than one of three request flags is set.
package mem_return_pkg;

   typedef enum logic [1:0] {
      K_NONE     = 2'd0,
      K_RELOAD   = 2'd1,
      K_DSTACK   = 2'd2,
      K_CONVEYOR = 2'd3
   } kind_e;

   localparam int unsigned NUM_DC = 4;

   typedef struct packed {
      logic       valid;
      kind_e      kind;
      logic [1:0] choice;
      logic       fwd_valid;
   } stage_meta_t;

   function automatic logic multi_hot3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/mem_return_stage.sv
// mem_return_stage: one register of the read-tracking pipe.
//   Captures the previous stage (or the issuing request) every cycle. If a
//   write to the same address happens in the cycle the entry is captured, the
//   write data replaces any older forwarded value, so the youngest write wins
//   and a write in the issue cycle is seen by the read (write-first).
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   in_meta/in_addr/in_fwd_value  - entry arriving at this stage
//   write_out/write_address/write_value - this cycle's memory write
//   out_meta/out_addr/out_fwd_value - registered entry held by this stage
module mem_return_stage
   import mem_return_pkg::*;
#(
   parameter int unsigned MAIN_ADDR_WIDTH = 1,
   parameter int unsigned WORD_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  stage_meta_t                in_meta,
   input  logic [MAIN_ADDR_WIDTH-1:0] in_addr,
   input  logic [WORD_WIDTH-1:0]      in_fwd_value,
   input  logic                       write_out,
   input  logic [MAIN_ADDR_WIDTH-1:0] write_address,
   input  logic [WORD_WIDTH-1:0]      write_value,
   output stage_meta_t                out_meta,
   output logic [MAIN_ADDR_WIDTH-1:0] out_addr,
   output logic [WORD_WIDTH-1:0]      out_fwd_value
);

   stage_meta_t                meta_d, meta_q;
   logic [MAIN_ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [WORD_WIDTH-1:0]      fwd_d,  fwd_q;

   // Next entry: pass through, overriding the forwarded word on an address hit.
   always_comb begin
      meta_d = in_meta;
      addr_d = in_addr;
      fwd_d  = in_fwd_value;
      if (in_meta.valid && write_out && (write_address == in_addr)) begin
         meta_d.fwd_valid = 1'b1;
         fwd_d            = write_value;
      end else begin
         fwd_d = in_fwd_value;
      end
   end

   // Stage register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         addr_q <= '0;
         fwd_q  <= '0;
      end else begin
         meta_q <= meta_d;
         addr_q <= addr_d;
         fwd_q  <= fwd_d;
      end
   end

   assign out_meta      = meta_q;
   assign out_addr      = addr_q;
   assign out_fwd_value = fwd_q;

endmodule

// File: rtl/mem_return.sv
// mem_return: return-path unit for main memory.
//   Tracks every read through a READ_LATENCY-deep pipe that mirrors the
//   synchronous memory, forwards younger writes into in-flight reads, and
//   steers each returned word to a dc value register, the data stack load
//   port or the conveyor load port. All outputs are registered.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   reload/choice                  - dc reload request and its dc index
//   dstack_memload/conveyor_memload - load requests for stack / conveyor
//   read_address                   - address of this cycle's read
//   write_out/write_address/write_value - this cycle's write
//   mem_read_data                  - memory data for the read issued READ_LATENCY ago
//   dc_vals/dc_vals_valid          - dc value registers and their currency flags
//   dstack_load_*/conveyor_load_*  - one-cycle load result pulses
//   busy                           - any read in flight
//   protocol_error                 - sticky: conflicting request flags seen
module mem_return
   import mem_return_pkg::*;
#(
   parameter int unsigned MAIN_ADDR_WIDTH = 1,
   parameter int unsigned WORD_WIDTH      = 32,
   parameter int unsigned READ_LATENCY    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         reload,
   input  logic [1:0]                   choice,
   input  logic                         dstack_memload,
   input  logic                         conveyor_memload,
   input  logic [MAIN_ADDR_WIDTH-1:0]   read_address,
   input  logic                         write_out,
   input  logic [MAIN_ADDR_WIDTH-1:0]   write_address,
   input  logic [WORD_WIDTH-1:0]        write_value,
   input  logic [WORD_WIDTH-1:0]        mem_read_data,
   output logic [3:0][WORD_WIDTH-1:0]   dc_vals,
   output logic [3:0]                   dc_vals_valid,
   output logic                         dstack_load_valid,
   output logic [WORD_WIDTH-1:0]        dstack_load_value,
   output logic                         conveyor_load_valid,
   output logic [WORD_WIDTH-1:0]        conveyor_load_value,
   output logic                         busy,
   output logic                         protocol_error
);

   localparam int LAST = int'(READ_LATENCY) - 1;

   // Pipe wiring: *_in_s feeds stage g, *_out_s is what stage g holds.
   stage_meta_t                meta_in_s  [READ_LATENCY];
   logic [MAIN_ADDR_WIDTH-1:0] addr_in_s  [READ_LATENCY];
   logic [WORD_WIDTH-1:0]      fwd_in_s   [READ_LATENCY];
   stage_meta_t                meta_out_s [READ_LATENCY];
   logic [MAIN_ADDR_WIDTH-1:0] addr_out_s [READ_LATENCY];
   logic [WORD_WIDTH-1:0]      fwd_out_s  [READ_LATENCY];

   stage_meta_t                issue_meta_s;
   logic                       issue_reload_s;
   logic                       younger_reload_s;
   logic                       ret_reload_ok_s;
   logic [WORD_WIDTH-1:0]      ret_data_s;
   stage_meta_t                last_s;

   logic [3:0][WORD_WIDTH-1:0] dc_vals_d,             dc_vals_q;
   logic [3:0]                 dc_vals_valid_d,       dc_vals_valid_q;
   logic                       dstack_load_valid_d,   dstack_load_valid_q;
   logic [WORD_WIDTH-1:0]      dstack_load_value_d,   dstack_load_value_q;
   logic                       conveyor_load_valid_d, conveyor_load_valid_q;
   logic [WORD_WIDTH-1:0]      conveyor_load_value_d, conveyor_load_value_q;
   logic                       busy_d,                busy_q;
   logic                       protocol_error_d,      protocol_error_q;

   // Request decode: reload > dstack > conveyor > none.
   always_comb begin
      issue_meta_s           = '0;
      issue_meta_s.choice    = choice;
      issue_meta_s.fwd_valid = 1'b0;
      if (reload) begin
         issue_meta_s.kind = K_RELOAD;
      end else if (dstack_memload) begin
         issue_meta_s.kind = K_DSTACK;
      end else if (conveyor_memload) begin
         issue_meta_s.kind = K_CONVEYOR;
      end else begin
         issue_meta_s.kind = K_NONE;
      end
      issue_meta_s.valid = (issue_meta_s.kind != K_NONE);
      issue_reload_s     = (issue_meta_s.kind == K_RELOAD);
   end

   for (genvar g = 0; g < int'(READ_LATENCY); g++) begin : g_stage
      if (g == 0) begin : g_head
         assign meta_in_s[g] = issue_meta_s;
         assign addr_in_s[g] = read_address;
         assign fwd_in_s[g]  = '0;
      end else begin : g_chain
         assign meta_in_s[g] = meta_out_s[g-1];
         assign addr_in_s[g] = addr_out_s[g-1];
         assign fwd_in_s[g]  = fwd_out_s[g-1];
      end

      mem_return_stage #(
         .MAIN_ADDR_WIDTH (MAIN_ADDR_WIDTH),
         .WORD_WIDTH      (WORD_WIDTH)
      ) u_stage (
         .clk           (clk),
         .reset         (reset),
         .in_meta       (meta_in_s[g]),
         .in_addr       (addr_in_s[g]),
         .in_fwd_value  (fwd_in_s[g]),
         .write_out     (write_out),
         .write_address (write_address),
         .write_value   (write_value),
         .out_meta      (meta_out_s[g]),
         .out_addr      (addr_out_s[g]),
         .out_fwd_value (fwd_out_s[g])
      );
   end

   // Returning data; a write landing in the return cycle is the youngest of all.
   always_comb begin
      last_s = meta_out_s[LAST];
      if (write_out && (write_address == addr_out_s[LAST])) begin
         ret_data_s = write_value;
      end else if (last_s.fwd_valid) begin
         ret_data_s = fwd_out_s[LAST];
      end else begin
         ret_data_s = mem_read_data;
      end
   end

   // A returning reload is stale if any younger reload to the same dc is
   // in the pipe or issuing right now.
   always_comb begin
      younger_reload_s = issue_reload_s && (choice == last_s.choice);
      for (int k = 0; k < LAST; k++) begin
         if (meta_out_s[k].valid && (meta_out_s[k].kind == K_RELOAD) &&
             (meta_out_s[k].choice == last_s.choice)) begin
            younger_reload_s = 1'b1;
         end else begin
            younger_reload_s = younger_reload_s;
         end
      end
      ret_reload_ok_s = last_s.valid && (last_s.kind == K_RELOAD) && !younger_reload_s;
   end

   // Output next-state: dc registers, load pulses, busy, sticky error.
   always_comb begin
      for (int i = 0; i < int'(NUM_DC); i++) begin
         if (issue_reload_s && (choice == 2'(i))) begin
            dc_vals_d[i]       = dc_vals_q[i];
            dc_vals_valid_d[i] = 1'b0;
         end else if (ret_reload_ok_s && (last_s.choice == 2'(i))) begin
            dc_vals_d[i]       = ret_data_s;
            dc_vals_valid_d[i] = 1'b1;
         end else begin
            dc_vals_d[i]       = dc_vals_q[i];
            dc_vals_valid_d[i] = dc_vals_valid_q[i];
         end
      end

      dstack_load_valid_d   = last_s.valid && (last_s.kind == K_DSTACK);
      conveyor_load_valid_d = last_s.valid && (last_s.kind == K_CONVEYOR);
      dstack_load_value_d   = dstack_load_valid_d   ? ret_data_s : dstack_load_value_q;
      conveyor_load_value_d = conveyor_load_valid_d ? ret_data_s : conveyor_load_value_q;

      // Registered busy reflects what the stages will hold after this edge.
      busy_d = 1'b0;
      for (int k = 0; k < int'(READ_LATENCY); k++) begin
         busy_d = busy_d | meta_in_s[k].valid;
      end

      protocol_error_d = protocol_error_q |
                         multi_hot3(reload, dstack_memload, conveyor_memload);
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dc_vals_q             <= '0;
         dc_vals_valid_q       <= 4'b1111;
         dstack_load_valid_q   <= 1'b0;
         dstack_load_value_q   <= '0;
         conveyor_load_valid_q <= 1'b0;
         conveyor_load_value_q <= '0;
         busy_q                <= 1'b0;
         protocol_error_q      <= 1'b0;
      end else begin
         dc_vals_q             <= dc_vals_d;
         dc_vals_valid_q       <= dc_vals_valid_d;
         dstack_load_valid_q   <= dstack_load_valid_d;
         dstack_load_value_q   <= dstack_load_value_d;
         conveyor_load_valid_q <= conveyor_load_valid_d;
         conveyor_load_value_q <= conveyor_load_value_d;
         busy_q                <= busy_d;
         protocol_error_q      <= protocol_error_d;
      end
   end

   assign dc_vals             = dc_vals_q;
   assign dc_vals_valid       = dc_vals_valid_q;
   assign dstack_load_valid   = dstack_load_valid_q;
   assign dstack_load_value   = dstack_load_value_q;
   assign conveyor_load_valid = conveyor_load_valid_q;
   assign conveyor_load_value = conveyor_load_value_q;
   assign busy                = busy_q;
   assign protocol_error      = protocol_error_q;

endmodule

// File: tb/tb_mem_return.sv
// tb_mem_return: directed scoreboard bench for mem_return.
//   Stimulus pushes expected load values into per-port queues; a monitor on
//   the falling edge pops and compares whenever a load pulse appears. A small
//   shift register plays the fixed-latency memory.
module tb_mem_return;

   localparam int AW = 8;
   localparam int WW = 32;
   localparam int RL = 2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 reload = 1'b0;
   logic [1:0]           choice = 2'd0;
   logic                 dstack_memload = 1'b0;
   logic                 conveyor_memload = 1'b0;
   logic [AW-1:0]        read_address = '0;
   logic                 write_out = 1'b0;
   logic [AW-1:0]        write_address = '0;
   logic [WW-1:0]        write_value = '0;
   logic [WW-1:0]        mem_read_data = '0;
   logic [3:0][WW-1:0]   dc_vals;
   logic [3:0]           dc_vals_valid;
   logic                 dstack_load_valid;
   logic [WW-1:0]        dstack_load_value;
   logic                 conveyor_load_valid;
   logic [WW-1:0]        conveyor_load_value;
   logic                 busy;
   logic                 protocol_error;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [WW-1:0] dq[$];
   logic [WW-1:0] cq[$];
   logic [WW-1:0] mem_pipe [RL];

   mem_return #(
      .MAIN_ADDR_WIDTH (AW),
      .WORD_WIDTH      (WW),
      .READ_LATENCY    (RL)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .reload              (reload),
      .choice              (choice),
      .dstack_memload      (dstack_memload),
      .conveyor_memload    (conveyor_memload),
      .read_address        (read_address),
      .write_out           (write_out),
      .write_address       (write_address),
      .write_value         (write_value),
      .mem_read_data       (mem_read_data),
      .dc_vals             (dc_vals),
      .dc_vals_valid       (dc_vals_valid),
      .dstack_load_valid   (dstack_load_valid),
      .dstack_load_value   (dstack_load_value),
      .conveyor_load_valid (conveyor_load_valid),
      .conveyor_load_value (conveyor_load_value),
      .busy                (busy),
      .protocol_error      (protocol_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One cycle: present a request, let the edge sample it, then advance the
   // memory model so md appears on mem_read_data RL edges after issue.
   task automatic drive(input logic rl, input logic [1:0] ch, input logic ds, input logic cv,
                        input logic [AW-1:0] ra, input logic wo, input logic [AW-1:0] wa,
                        input logic [WW-1:0] wv, input logic [WW-1:0] md);
      reload = rl; choice = ch; dstack_memload = ds; conveyor_memload = cv;
      read_address = ra; write_out = wo; write_address = wa; write_value = wv;
      @(posedge clk);
      #1;
      for (int i = RL - 1; i > 0; i--) mem_pipe[i] = mem_pipe[i-1];
      mem_pipe[0] = md;
      mem_read_data = mem_pipe[RL-1];
      reload = 1'b0; dstack_memload = 1'b0; conveyor_memload = 1'b0; write_out = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 32'd0, 32'hBAD0_BAD0);
   endtask

   // Monitor: compare each load pulse against the scoreboard queues.
   initial begin
      forever begin
         @(negedge clk);
         if (dstack_load_valid || conveyor_load_valid)
            check("one_load_valid", {31'd0, dstack_load_valid & conveyor_load_valid}, 32'd0);
         if (dstack_load_valid) begin
            if (dq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL dstack_unexpected: got pulse 0x%0h, expected none", dstack_load_value);
            end else begin
               check("dstack_value", dstack_load_value, dq.pop_front());
            end
         end
         if (conveyor_load_valid) begin
            if (cq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL conveyor_unexpected: got pulse 0x%0h, expected none", conveyor_load_value);
            end else begin
               check("conveyor_value", conveyor_load_value, cq.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < RL; i++) mem_pipe[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_mask", {28'd0, dc_vals_valid}, 32'hF);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_perr", {31'd0, protocol_error}, 32'd0);
      check("rst_dstack_v", {31'd0, dstack_load_valid}, 32'd0);
      check("rst_conv_v", {31'd0, conveyor_load_valid}, 32'd0);
      for (int i = 0; i < 4; i++) check("rst_dc_val", dc_vals[i], 32'd0);
      reset = 1'b0;
      idle();

      // Reload dc[2] from addr 5.
      drive(1'b1, 2'd2, 1'b0, 1'b0, 8'd5, 1'b0, 8'd0, 32'd0, 32'hDEAD);
      check("rl_valid_t1", {28'd0, dc_vals_valid}, 32'hB);
      check("rl_busy", {31'd0, busy}, 32'd1);
      idle();
      check("rl_valid_t2", {28'd0, dc_vals_valid}, 32'hB);
      check("rl_old_val", dc_vals[2], 32'd0);
      idle();
      check("rl_valid_t3", {28'd0, dc_vals_valid}, 32'hF);
      check("rl_value", dc_vals[2], 32'hDEAD);
      idle();

      // dstack: forwarding from a younger write.
      dq.push_back(32'h77);
      drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd3, 1'b0, 8'd0, 32'd0, 32'h11);
      drive(1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd3, 32'h77, 32'hBAD0_BAD0);
      // Plain read, no forwarding.
      dq.push_back(32'h1234);
      drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd9, 1'b0, 8'd0, 32'd0, 32'h1234);
      // Write in the issue cycle is captured.
      dq.push_back(32'h55);
      drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd4, 1'b1, 8'd4, 32'h55, 32'h99);
      // Youngest of two writes wins.
      dq.push_back(32'hA2);
      drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd6, 1'b1, 8'd6, 32'hA1, 32'h1);
      drive(1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd6, 32'hA2, 32'hBAD0_BAD0);
      // Write to another address does not forward.
      dq.push_back(32'h7777);
      drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd7, 1'b0, 8'd0, 32'd0, 32'h7777);
      drive(1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd8, 32'h8888, 32'hBAD0_BAD0);
      repeat (3) idle();

      // Back-to-back reloads to dc[1]: first return is stale.
      drive(1'b1, 2'd1, 1'b0, 1'b0, 8'd10, 1'b0, 8'd0, 32'd0, 32'hA);
      check("b2b_valid_t1", {31'd0, dc_vals_valid[1]}, 32'd0);
      drive(1'b1, 2'd1, 1'b0, 1'b0, 8'd11, 1'b0, 8'd0, 32'd0, 32'hB);
      check("b2b_valid_t2", {31'd0, dc_vals_valid[1]}, 32'd0);
      idle();
      check("b2b_valid_t3", {31'd0, dc_vals_valid[1]}, 32'd0);
      check("b2b_stale_drop", dc_vals[1], 32'd0);
      idle();
      check("b2b_valid_t4", {31'd0, dc_vals_valid[1]}, 32'd1);
      check("b2b_value", dc_vals[1], 32'hB);

      // Conveyor stream, one read per cycle.
      for (int i = 0; i < 8; i++) begin
         cq.push_back(32'hC000 + i);
         drive(1'b0, 2'd0, 1'b0, 1'b1, 8'(i), 1'b0, 8'd0, 32'd0, 32'hC000 + i);
         check("conv_busy", {31'd0, busy}, 32'd1);
      end
      idle();
      check("conv_busy_tail", {31'd0, busy}, 32'd1);
      idle();
      check("conv_busy_done", {31'd0, busy}, 32'd0);
      idle();

      // Conflicting request flags: reload wins, error is sticky.
      drive(1'b1, 2'd0, 1'b1, 1'b0, 8'd20, 1'b0, 8'd0, 32'd0, 32'h5A5A);
      check("perr_set", {31'd0, protocol_error}, 32'd1);
      check("perr_rl_valid", {31'd0, dc_vals_valid[0]}, 32'd0);
      idle();
      idle();
      check("perr_rl_value", dc_vals[0], 32'h5A5A);
      check("perr_rl_valid2", {31'd0, dc_vals_valid[0]}, 32'd1);
      repeat (3) idle();
      check("perr_sticky", {31'd0, protocol_error}, 32'd1);

      // Reset with two reads in flight.
      drive(1'b0, 2'd0, 1'b1, 1'b0, 8'd1, 1'b0, 8'd0, 32'd0, 32'h1);
      drive(1'b1, 2'd3, 1'b0, 1'b0, 8'd2, 1'b0, 8'd0, 32'd0, 32'h2);
      check("mid_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #2;
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_valid_mask", {28'd0, dc_vals_valid}, 32'hF);
      check("mid_dc2", dc_vals[2], 32'd0);
      check("mid_perr", {31'd0, protocol_error}, 32'd0);
      idle();
      reset = 1'b0;
      repeat (4) idle();
      check("post_valid_mask", {28'd0, dc_vals_valid}, 32'hF);
      check("post_busy", {31'd0, busy}, 32'd0);

      check("dq_drained", 32'(dq.size()), 32'd0);
      check("cq_drained", 32'(cq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
